// File: rtl/mem_stage_seq.sv
// mem_stage_seq: MEM-stage data-memory access sequencer for the pipelined
// LC-3b datapath. Issues word, byte and two-access indirect (LDI/STI)
// requests, formats load data for WB and stalls the pipe while an access
// is outstanding.
// Optional build macro MEM_STAGE_PERF_EN adds a saturating stall counter
// on output stall_cycles.
module mem_stage_seq #(
  parameter int ADDR_W = 16,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [3:0]        opcode,
  input  logic              ldi_sti,
  input  logic              ldb_sel,
  input  logic              stb_sel,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] src_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] load_data,
  output logic              stall,
  output logic              done
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles
`endif
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PTR   = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  logic [1:0]        state, state_nx;
  // Pointer bit 0 is never used (final indirect access is word aligned).
  logic [ADDR_W-1:1] ptr_reg;
  logic [ADDR_W-1:0] load_q;
  logic              mem_op, is_store, final_acc, final_resp;
  logic [ADDR_W-1:0] direct_addr;

  // Byte loads pick the lane named by address bit 0 and zero-extend it.
  function automatic logic [ADDR_W-1:0] fmt_load(input logic [ADDR_W-1:0] rdata,
                                                 input logic byte_ld,
                                                 input logic hi_lane);
    if (!byte_ld)
      return rdata;
    else if (hi_lane)
      return {{(ADDR_W-8){1'b0}}, rdata[15:8]};
    else
      return {{(ADDR_W-8){1'b0}}, rdata[7:0]};
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (&v)
      return v;
    else
      return v + 1'b1;
  endfunction

  // Request generation, handshake and completion decode.
  always_comb begin
    mem_op = valid_in && !reset &&
             ((opcode == OP_LDR) || (opcode == OP_LDB) || (opcode == OP_LDI) ||
              (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI));
    is_store    = (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
    // The pointer read is the only access that is not the final one.
    final_acc   = (state == FINAL) || ((state == IDLE) && !ldi_sti);
    direct_addr = (ldb_sel || stb_sel) ? addr_in : {addr_in[ADDR_W-1:1], 1'b0};

    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_wdata       = '0;
    final_resp      = 1'b0;
    stall           = 1'b0;
    done            = 1'b0;

    if (mem_op) begin
      if (!final_acc) begin
        mem_address     = {addr_in[ADDR_W-1:1], 1'b0};
        mem_read        = 1'b1;
        mem_byte_enable = 2'b11;
      end else begin
        mem_address = ldi_sti ? {ptr_reg, 1'b0} : direct_addr;
        if (is_store) begin
          mem_write = 1'b1;
          if (stb_sel) begin
            mem_wdata       = {src_data[7:0], src_data[7:0]};
            mem_byte_enable = addr_in[0] ? 2'b10 : 2'b01;
          end else begin
            mem_wdata       = src_data;
            mem_byte_enable = 2'b11;
          end
        end else begin
          mem_read        = 1'b1;
          mem_byte_enable = 2'b11;
        end
      end
      final_resp = mem_resp && final_acc;
      done       = final_resp;
      stall      = !final_resp;
    end

    // Completion cycle forwards the fresh read data; otherwise hold.
    if (reset)
      load_data = '0;
    else if (final_resp && !is_store)
      load_data = fmt_load(mem_rdata, ldb_sel, addr_in[0]);
    else
      load_data = load_q;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (ldi_sti)
            state_nx = mem_resp ? FINAL : PTR;
          else
            state_nx = mem_resp ? IDLE : FINAL;
        end
      end
      PTR: begin
        if (!mem_op)
          state_nx = IDLE;
        else if (mem_resp)
          state_nx = FINAL;
      end
      FINAL: begin
        if (!mem_op || mem_resp)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, pointer latch and held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr_reg <= '0;
      load_q  <= '0;
    end else begin
      state <= state_nx;
      if (mem_op && mem_resp && !final_acc)
        ptr_reg <= mem_rdata[ADDR_W-1:1];
      if (final_resp && !is_store)
        load_q <= fmt_load(mem_rdata, ldb_sel, addr_in[0]);
    end
  end

`ifdef MEM_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_q;

  // Count stalled cycles, saturating.
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (stall)
      stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = reset ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_seq.sv
// tb_mem_stage_seq: scoreboard bench for mem_stage_seq. A memory responder
// with random latency serves requests; a reference model builds the list of
// expected accesses and load results per instruction; a negedge monitor
// checks every cycle against the queued expectations.
module tb_mem_stage_seq;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic        clk, reset, valid_in, ldi_sti, ldb_sel, stb_sel;
  logic [3:0]  opcode;
  logic [15:0] addr_in, src_data, mem_address, mem_wdata, mem_rdata, load_data;
  logic        mem_read, mem_write, mem_resp, stall, done;
  logic [1:0]  mem_byte_enable;
`ifdef MEM_STAGE_PERF_EN
  logic [15:0] stall_cycles;
`endif

  mem_stage_seq #(.ADDR_W(16), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .ldi_sti(ldi_sti), .ldb_sel(ldb_sel), .stb_sel(stb_sel),
    .addr_in(addr_in), .src_data(src_data),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .load_data(load_data), .stall(stall), .done(done)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic        rd;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        last;
  } acc_t;

  typedef struct packed {
    logic        ld;
    logic [15:0] v;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] dut_mem[logic [15:0]];

  int          checks = 0;
  int          errors = 0;
  int          force_lat = -1;
  logic        force_resp = 1'b0;
  logic [15:0] exp_hold = 16'h0;
  logic [15:0] exp_stall = 16'h0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h1234;
  endfunction

  function automatic logic [15:0] align(input logic [15:0] a);
    return {a[15:1], 1'b0};
  endfunction

  function automatic logic [15:0] rd_ref(input logic [15:0] a);
    if (ref_mem.exists(align(a))) return ref_mem[align(a)];
    return init_val(align(a));
  endfunction

  function automatic logic [15:0] rd_dut(input logic [15:0] a);
    if (dut_mem.exists(align(a))) return dut_mem[align(a)];
    return init_val(align(a));
  endfunction

  function automatic acc_t mk_acc(input logic [15:0] a, input logic rd,
                                  input logic [1:0] be, input logic [15:0] wd,
                                  input logic last);
    acc_t x;
    x.a = a; x.rd = rd; x.be = be; x.wd = wd; x.last = last;
    return x;
  endfunction

  function automatic res_t mk_res(input logic ld, input logic [15:0] v);
    res_t r;
    r.ld = ld; r.v = v;
    return r;
  endfunction

  // Reference model: expected memory accesses and result of one instruction.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s);
    logic [15:0] w, p;
    case (op)
      OP_LDR: begin
        acc_q.push_back(mk_acc(align(a), 1'b1, 2'b11, 16'h0, 1'b1));
        res_q.push_back(mk_res(1'b1, rd_ref(a)));
      end
      OP_LDB: begin
        w = rd_ref(a);
        acc_q.push_back(mk_acc(a, 1'b1, 2'b11, 16'h0, 1'b1));
        res_q.push_back(mk_res(1'b1, a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]}));
      end
      OP_STR: begin
        acc_q.push_back(mk_acc(align(a), 1'b0, 2'b11, s, 1'b1));
        ref_mem[align(a)] = s;
        res_q.push_back(mk_res(1'b0, 16'h0));
      end
      OP_STB: begin
        w = rd_ref(a);
        acc_q.push_back(mk_acc(a, 1'b0, a[0] ? 2'b10 : 2'b01, {s[7:0], s[7:0]}, 1'b1));
        if (a[0]) w[15:8] = s[7:0]; else w[7:0] = s[7:0];
        ref_mem[align(a)] = w;
        res_q.push_back(mk_res(1'b0, 16'h0));
      end
      OP_LDI: begin
        p = rd_ref(a);
        acc_q.push_back(mk_acc(align(a), 1'b1, 2'b11, 16'h0, 1'b0));
        acc_q.push_back(mk_acc(align(p), 1'b1, 2'b11, 16'h0, 1'b1));
        res_q.push_back(mk_res(1'b1, rd_ref(p)));
      end
      default: begin
        p = rd_ref(a);
        acc_q.push_back(mk_acc(align(a), 1'b1, 2'b11, 16'h0, 1'b0));
        acc_q.push_back(mk_acc(align(p), 1'b0, 2'b11, s, 1'b1));
        ref_mem[align(p)] = s;
        res_q.push_back(mk_res(1'b0, 16'h0));
      end
    endcase
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    ref_mem[align(a)] = v;
    dut_mem[align(a)] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    acc_q.delete();
    res_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_inputs(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s);
    valid_in = 1'b1;
    opcode   = op;
    ldi_sti  = (op == OP_LDI) || (op == OP_STI);
    ldb_sel  = (op == OP_LDB);
    stb_sel  = (op == OP_STB);
    addr_in  = a;
    src_data = s;
  endtask

  // Present one memory op, hold it until done, then drop valid_in.
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s,
                       input int lat, output int ncyc);
    bit got;
    got = 1'b0;
    ncyc = 0;
    force_lat = lat;
    set_inputs(op, a, s);
    model(op, a, s);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      ncyc++;
      if (done === 1'b1) got = 1'b1;
    end
    @(posedge clk);
    #1;
    force_lat = -1;
    valid_in = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL op_timeout op=%h addr=%h got no done within 100 cycles", op, a);
      do_reset();
    end
  endtask

  // Memory responder with random (or forced) latency.
  initial begin
    int wait_cnt;
    logic [15:0] w;
    mem_resp = 1'b0;
    mem_rdata = 16'h0;
    wait_cnt = -1;
    forever begin
      @(posedge clk);
      #2;
      if (!(mem_read || mem_write)) begin
        wait_cnt = -1;
        mem_resp = force_resp || ($urandom_range(0, 4) == 0);
        mem_rdata = 16'($urandom);
      end else begin
        if (wait_cnt < 0)
          wait_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          mem_resp = 1'b1;
          if (mem_read) begin
            mem_rdata = rd_dut(mem_address);
          end else begin
            w = rd_dut(mem_address);
            if (mem_byte_enable[1]) w[15:8] = mem_wdata[15:8];
            if (mem_byte_enable[0]) w[7:0] = mem_wdata[7:0];
            dut_mem[align(mem_address)] = w;
            mem_rdata = 16'($urandom);
          end
          wait_cnt = -1;
        end else begin
          mem_resp = 1'b0;
          mem_rdata = 16'($urandom);
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the expected access/result queues.
  always @(negedge clk) begin
    acc_t f;
    res_t r;
    logic last_resp, ld_seen;
    ld_seen = 1'b0;
    if (reset) begin
      checks++;
      if (mem_read || mem_write || stall || done || mem_address != 16'h0 ||
          mem_byte_enable != 2'b00 || mem_wdata != 16'h0 || load_data != 16'h0) begin
        errors++;
        $display("FAIL reset_outputs rd=%b wr=%b stall=%b done=%b addr=%h be=%b wd=%h ld=%h, all must be 0",
                 mem_read, mem_write, stall, done, mem_address, mem_byte_enable, mem_wdata, load_data);
      end
`ifdef MEM_STAGE_PERF_EN
      checks++;
      if (stall_cycles != 16'h0) begin
        errors++;
        $display("FAIL reset_perf stall_cycles=%0d required 0", stall_cycles);
      end
`endif
      exp_hold = 16'h0;
      exp_stall = 16'h0;
    end else begin
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rw_exclusive read and write both 1 at addr=%h", mem_address);
      end
      if (mem_read || mem_write) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req rd=%b wr=%b addr=%h with nothing outstanding",
                   mem_read, mem_write, mem_address);
        end else begin
          f = acc_q[0];
          if (mem_address !== f.a || mem_read !== f.rd || mem_write !== !f.rd ||
              mem_byte_enable !== f.be || (!f.rd && mem_wdata !== f.wd)) begin
            errors++;
            $display("FAIL access got addr=%h rd=%b wr=%b be=%b wd=%h required addr=%h rd=%b wr=%b be=%b wd=%h",
                     mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
                     f.a, f.rd, !f.rd, f.be, f.wd);
          end
          last_resp = mem_resp && f.last;
          checks++;
          if (stall !== !last_resp || done !== last_resp) begin
            errors++;
            $display("FAIL handshake stall=%b done=%b required stall=%b done=%b",
                     stall, done, !last_resp, last_resp);
          end
          if (!last_resp) exp_stall = exp_stall + 16'h1;
          if (mem_resp) void'(acc_q.pop_front());
          if (last_resp) begin
            checks++;
            if (res_q.size() == 0) begin
              errors++;
              $display("FAIL result_queue done with no expected result");
            end else begin
              r = res_q.pop_front();
              if (r.ld) begin
                ld_seen = 1'b1;
                checks++;
                if (load_data !== r.v) begin
                  errors++;
                  $display("FAIL load_data got %h required %h", load_data, r.v);
                end
                exp_hold = r.v;
              end
            end
          end
        end
      end else begin
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle_quiet stall=%b done=%b required 0 0", stall, done);
        end
      end
      if (!ld_seen) begin
        checks++;
        if (load_data !== exp_hold) begin
          errors++;
          $display("FAIL load_hold got %h required %h", load_data, exp_hold);
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int n;
    logic [3:0] op;
    logic [3:0] mem_ops[6];
    mem_ops = '{OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
    reset = 1'b1;
    valid_in = 1'b0;
    opcode = OP_ADD;
    ldi_sti = 1'b0;
    ldb_sel = 1'b0;
    stb_sel = 1'b0;
    addr_in = 16'h0;
    src_data = 16'h0;
    tick();
    do_reset();

    // LDR with two wait cycles: three cycles to done.
    poke(16'h3004, 16'h1234);
    do_op(OP_LDR, 16'h3005, 16'h0, 2, n);
    checks++;
    if (n != 3 || load_data !== 16'h1234) begin
      errors++;
      $display("FAIL ldr_latency cycles=%0d data=%h required 3 1234", n, load_data);
    end

    // Byte loads from both lanes, back to back.
    poke(16'h2000, 16'hABCD);
    do_op(OP_LDB, 16'h2001, 16'h0, -1, n);
    do_op(OP_LDB, 16'h2000, 16'h0, -1, n);
    checks++;
    if (load_data !== 16'h00CD) begin
      errors++;
      $display("FAIL ldb_low got %h required 00cd", load_data);
    end

    // Byte store to the high lane.
    do_op(OP_STB, 16'h4003, 16'h1177, 1, n);

    // Indirect load, one wait cycle on each access.
    poke(16'h5000, 16'h6001);
    poke(16'h6000, 16'hBEEF);
    do_op(OP_LDI, 16'h5000, 16'h0, 1, n);
    checks++;
    if (n != 4 || load_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL ldi_result cycles=%0d data=%h required 4 beef", n, load_data);
    end

    // STI abandoned by reset during the pointer wait, then a late resp.
    poke(16'h7000, 16'h7100);
    force_lat = 6;
    set_inputs(OP_STI, 16'h7000, 16'h5555);
    model(OP_STI, 16'h7000, 16'h5555);
    tick();
    tick();
    reset = 1'b1;
    valid_in = 1'b0;
    acc_q.delete();
    res_q.delete();
    ref_mem[16'h7100] = rd_dut(16'h7100);
    tick();
    reset = 1'b0;
    force_lat = -1;
    force_resp = 1'b1;
    tick();
    force_resp = 1'b0;
    checks++;
    if (mem_read || mem_write || stall || done) begin
      errors++;
      $display("FAIL post_reset rd=%b wr=%b stall=%b done=%b required 0",
               mem_read, mem_write, stall, done);
    end
    do_op(OP_LDB, 16'h7001, 16'h0, 0, n);
    checks++;
    if (n != 1 || load_data !== 16'h0071) begin
      errors++;
      $display("FAIL restart cycles=%0d data=%h required 1 0071", n, load_data);
    end

    // Non-memory op with resp pulses: must stay quiet.
    set_inputs(OP_ADD, 16'h3000, 16'h1);
    force_resp = 1'b1;
    tick();
    tick();
    force_resp = 1'b0;
    valid_in = 1'b0;

    // Randomized mix of memory ops and idle / non-memory cycles.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        valid_in = 1'($urandom);
        op = 4'($urandom);
        if (valid_in) begin
          while (op == OP_LDR || op == OP_LDB || op == OP_LDI ||
                 op == OP_STR || op == OP_STB || op == OP_STI)
            op = 4'($urandom);
        end
        opcode = op;
        ldi_sti = 1'($urandom);
        ldb_sel = 1'($urandom);
        stb_sel = 1'($urandom);
        tick();
        valid_in = 1'b0;
      end else begin
        do_op(mem_ops[$urandom_range(0, 5)], {8'h70, 8'($urandom)}, 16'($urandom), -1, n);
      end
    end
    tick();

    checks++;
    if (acc_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL leftover accesses=%0d results=%0d required 0 0", acc_q.size(), res_q.size());
    end
`ifdef MEM_STAGE_PERF_EN
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL perf_count got %0d required %0d", stall_cycles, exp_stall);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
